// File: rtl/event_pkg.sv
// ============================================================================
// Module      : event_pkg
// Description : Shared types and sizing helpers for the event input path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package event_pkg;

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam int c_DEFAULT_DEBOUNCE = 16;

    // Counter must hold values up to DEBOUNCE_CYCLES-1 plus headroom for the +1 compare.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/event_sync_chain.sv
// ============================================================================
// Module      : event_sync_chain
// Description : Plain flop-chain synchronizer for one asynchronous level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_Data,
    output logic o_Sync
);

    logic [SYNC_STAGES-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;

    always_comb begin
        w_sync_d = {r_sync_q[SYNC_STAGES-2:0], i_Data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            r_sync_q <= w_sync_d;
        end
    end

    assign o_Sync = r_sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/event_input_conditioner.sv
// ============================================================================
// Module      : event_input_conditioner
// Description : Synchronizes and debounces a raw level; emits qualified edges
//               and flags/counts rejected short pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_input_conditioner
    import event_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE,
    parameter int   GLITCH_CNT_W    = 8,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_Data,
    input  logic                    i_Clear,
    output logic                    o_Data,
    output logic                    o_Rise,
    output logic                    o_Fall,
    output logic                    o_Glitch,
    output logic                    o_Busy,
    output logic [GLITCH_CNT_W-1:0] o_Glitch_Count
);

    localparam int                 c_CNT_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W:0]   c_CNT_LIMIT = (c_CNT_W + 1)'(DEBOUNCE_CYCLES);

    logic w_sync;

    state_t                  r_state_q,  w_state_d;
    logic [c_CNT_W-1:0]      r_cnt_q,    w_cnt_d;
    logic                    r_data_q,   w_data_d;
    logic                    r_rise_q,   w_rise_d;
    logic                    r_fall_q,   w_fall_d;
    logic                    r_glitch_q, w_glitch_d;
    logic [GLITCH_CNT_W-1:0] r_gcnt_q,   w_gcnt_d;
    logic                    w_commit;
    logic [c_CNT_W:0]        w_cnt_inc;

    event_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_Data (i_Data),
        .o_Sync (w_sync)
    );

    assign w_cnt_inc = {1'b0, r_cnt_q} + (c_CNT_W + 1)'(1);

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_data_d   = r_data_q;
        w_rise_d   = 1'b0;
        w_fall_d   = 1'b0;
        w_glitch_d = 1'b0;
        w_commit   = 1'b0;

        case (r_state_q)
            STABLE: begin
                if (w_sync != r_data_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_d = CHECK;
                        w_cnt_d   = c_CNT_W'(1);
                    end
                end else begin
                    w_cnt_d = '0;
                end
            end
            CHECK: begin
                if (w_sync != r_data_q) begin
                    if (w_cnt_inc == c_CNT_LIMIT) begin
                        w_commit = 1'b1;
                    end else begin
                        w_cnt_d = w_cnt_inc[c_CNT_W-1:0];
                    end
                end else begin
                    // Input fell back before qualifying: reject it.
                    w_state_d  = STABLE;
                    w_cnt_d    = '0;
                    w_glitch_d = 1'b1;
                end
            end
            default: begin
                w_state_d = STABLE;
                w_cnt_d   = '0;
            end
        endcase

        if (w_commit) begin
            w_data_d  = ~r_data_q;
            w_rise_d  = ~r_data_q;
            w_fall_d  = r_data_q;
            w_state_d = STABLE;
            w_cnt_d   = '0;
        end
    end

    // Clear has priority over a same-cycle rejection.
    always_comb begin
        w_gcnt_d = r_gcnt_q;
        if (i_Clear) begin
            w_gcnt_d = '0;
        end else if (w_glitch_d && (r_gcnt_q != {GLITCH_CNT_W{1'b1}})) begin
            w_gcnt_d = r_gcnt_q + GLITCH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= STABLE;
            r_cnt_q    <= '0;
            r_data_q   <= RESET_VALUE;
            r_rise_q   <= 1'b0;
            r_fall_q   <= 1'b0;
            r_glitch_q <= 1'b0;
            r_gcnt_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_data_q   <= w_data_d;
            r_rise_q   <= w_rise_d;
            r_fall_q   <= w_fall_d;
            r_glitch_q <= w_glitch_d;
            r_gcnt_q   <= w_gcnt_d;
        end
    end

    assign o_Data         = r_data_q;
    assign o_Rise         = r_rise_q;
    assign o_Fall         = r_fall_q;
    assign o_Glitch       = r_glitch_q;
    assign o_Busy         = (r_state_q == CHECK);
    assign o_Glitch_Count = r_gcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_event_input_conditioner.sv
// ============================================================================
// Module      : tb_event_input_conditioner
// Description : Directed self-checking bench for event_input_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_event_input_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_Data = 1'b0;
    logic       i_Clear = 1'b0;
    logic       o_Data, o_Rise, o_Fall, o_Glitch, o_Busy;
    logic [7:0] o_Glitch_Count;

    logic       i_Data1 = 1'b0;
    logic       i_Clear1 = 1'b0;
    logic       o_Data1, o_Rise1, o_Fall1, o_Glitch1, o_Busy1;
    logic [7:0] o_Glitch_Count1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    event_input_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16),
        .GLITCH_CNT_W    (8),
        .RESET_VALUE     (1'b0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_Data         (i_Data),
        .i_Clear        (i_Clear),
        .o_Data         (o_Data),
        .o_Rise         (o_Rise),
        .o_Fall         (o_Fall),
        .o_Glitch       (o_Glitch),
        .o_Busy         (o_Busy),
        .o_Glitch_Count (o_Glitch_Count)
    );

    event_input_conditioner #(
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1),
        .GLITCH_CNT_W    (8),
        .RESET_VALUE     (1'b0)
    ) dut_fast (
        .clk            (clk),
        .reset          (reset),
        .i_Data         (i_Data1),
        .i_Clear        (i_Clear1),
        .o_Data         (o_Data1),
        .o_Rise         (o_Rise1),
        .o_Fall         (o_Fall1),
        .o_Glitch       (o_Glitch1),
        .o_Busy         (o_Busy1),
        .o_Glitch_Count (o_Glitch_Count1)
    );

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic apply_reset();
        i_Data  = 1'b0;
        i_Data1 = 1'b0;
        i_Clear = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Vector order: {data, rise, fall, glitch, busy}
    task automatic test_reset();
        logic [4:0] exp_v;
        reset  = 1'b1;
        i_Data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_Data, o_Rise, o_Fall, o_Glitch, o_Busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp 00000", {o_Data, o_Rise, o_Fall, o_Glitch, o_Busy});
        end
        n_checks++;
        if (o_Glitch_Count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d exp 0", o_Glitch_Count);
        end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            exp_v = {k >= 18, k == 18, 1'b0, 1'b0, (k >= 3) && (k <= 17)};
            n_checks++;
            if ({o_Data, o_Rise, o_Fall, o_Glitch, o_Busy} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_release edge=%0d got %b exp %b", k,
                         {o_Data, o_Rise, o_Fall, o_Glitch, o_Busy}, exp_v);
            end
        end
    endtask

    task automatic test_clean_step();
        logic [4:0] exp_v;
        apply_reset();
        i_Data = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            exp_v = {k >= 18, k == 18, 1'b0, 1'b0, (k >= 3) && (k <= 17)};
            n_checks++;
            if ({o_Data, o_Rise, o_Fall, o_Glitch, o_Busy} !== exp_v) begin
                n_fail++;
                $display("FAIL clean_rise edge=%0d got %b exp %b", k,
                         {o_Data, o_Rise, o_Fall, o_Glitch, o_Busy}, exp_v);
            end
        end
        i_Data = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            exp_v = {k < 18, 1'b0, k == 18, 1'b0, (k >= 3) && (k <= 17)};
            n_checks++;
            if ({o_Data, o_Rise, o_Fall, o_Glitch, o_Busy} !== exp_v) begin
                n_fail++;
                $display("FAIL clean_fall edge=%0d got %b exp %b", k,
                         {o_Data, o_Rise, o_Fall, o_Glitch, o_Busy}, exp_v);
            end
        end
    endtask

    // 5-cycle high pulse from a settled low; rejection lands on edge 8.
    task automatic test_glitch_pulse(input bit clear_at_abort, input int exp_count);
        logic [4:0] exp_v;
        i_Data = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 6) i_Data = 1'b0;
            if (k == 8 && clear_at_abort) i_Clear = 1'b1;
            @(posedge clk);
            #1;
            i_Clear = 1'b0;
            exp_v = {1'b0, 1'b0, 1'b0, k == 8, (k >= 3) && (k <= 7)};
            n_checks++;
            if ({o_Data, o_Rise, o_Fall, o_Glitch, o_Busy} !== exp_v) begin
                n_fail++;
                $display("FAIL glitch_pulse edge=%0d got %b exp %b", k,
                         {o_Data, o_Rise, o_Fall, o_Glitch, o_Busy}, exp_v);
            end
        end
        n_checks++;
        if (o_Glitch_Count !== 8'(exp_count)) begin
            n_fail++;
            $display("FAIL glitch_count got %0d exp %0d", o_Glitch_Count, exp_count);
        end
    endtask

    task automatic test_single_glitch();
        apply_reset();
        test_glitch_pulse(1'b0, 1);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if ({o_Data, o_Glitch_Count} !== {1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL single_glitch_settle got data=%b count=%0d exp data=0 count=1",
                     o_Data, o_Glitch_Count);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int n = 1; n <= 300; n++) begin
            test_glitch_pulse(1'b0, (n > 255) ? 255 : n);
        end
        test_glitch_pulse(1'b1, 0);
        test_glitch_pulse(1'b0, 1);
    endtask

    task automatic test_reset_mid_check();
        logic [4:0] exp_v;
        apply_reset();
        i_Data = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (o_Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midcheck_busy_before got %b exp 1", o_Busy);
        end
        reset  = 1'b1;
        i_Data = 1'b0;
        #1;
        n_checks++;
        if ({o_Busy, o_Data} !== 2'b00) begin
            n_fail++;
            $display("FAIL midcheck_async got busy,data=%b exp 00", {o_Busy, o_Data});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({o_Data, o_Rise, o_Fall, o_Glitch, o_Busy} !== 5'b00000) begin
                n_fail++;
                $display("FAIL midcheck_quiet edge=%0d got %b exp 00000", k,
                         {o_Data, o_Rise, o_Fall, o_Glitch, o_Busy});
            end
        end
        i_Data = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            #1;
            exp_v = {k >= 18, k == 18, 1'b0, 1'b0, (k >= 3) && (k <= 17)};
            n_checks++;
            if ({o_Data, o_Rise, o_Fall, o_Glitch, o_Busy} !== exp_v) begin
                n_fail++;
                $display("FAIL midcheck_requalify edge=%0d got %b exp %b", k,
                         {o_Data, o_Rise, o_Fall, o_Glitch, o_Busy}, exp_v);
            end
        end
    endtask

    task automatic test_fast_config();
        logic [4:0] exp_v;
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) i_Data1 = 1'b1;
            if (k == 5) i_Data1 = 1'b0;
            @(posedge clk);
            #1;
            exp_v = {(k >= 4) && (k <= 7), k == 4, k == 8, 1'b0, 1'b0};
            n_checks++;
            if ({o_Data1, o_Rise1, o_Fall1, o_Glitch1, o_Busy1} !== exp_v) begin
                n_fail++;
                $display("FAIL fast_config edge=%0d got %b exp %b", k,
                         {o_Data1, o_Rise1, o_Fall1, o_Glitch1, o_Busy1}, exp_v);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_clean_step();
        test_single_glitch();
        test_back_to_back();
        test_reset_mid_check();
        test_fast_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
